// File: rtl/pipe_pal_pkg.sv
// pipe_pal_pkg: shared scheduler state encoding and burst counter width.
package pipe_pal_pkg;

  localparam int unsigned W_BURST_CNT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_pal_rr_pick.sv
// pipe_pal_rr_pick: combinational round-robin picker. Searches the request
// vector starting at last_grant+1 (mod N_REQ) and returns the first hit.
module pipe_pal_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_ID  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W_ID-1:0]  last_grant,
  output logic [W_ID-1:0]  grant_id,
  output logic             any_hit
);

  // Rotating priority search; the first match after last_grant wins.
  always_comb begin
    logic [W_ID-1:0] idx;
    grant_id = '0;
    any_hit  = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = W_ID'((32'(last_grant) + i) % N_REQ);
      if (!any_hit && req[idx]) begin
        any_hit  = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/pipe_pal_sched.sv
// pipe_pal_sched: round-robin burst scheduler feeding the shared pipe_pal
// datapath through a single registered output stage.
// Optional feature: define PIPE_PAL_SCHED_STATS_EN to add o_stall_cnt.
module pipe_pal_sched
  import pipe_pal_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned W_ID     = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*W_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_valid,
  output logic [W_DATA-1:0]       o_data,
  output logic [W_ID-1:0]         o_id,
  input  logic                    i_ready,
  output logic                    o_busy
`ifdef PIPE_PAL_SCHED_STATS_EN
  ,
  output logic [15:0]             o_stall_cnt
`endif
);

  localparam logic [W_BURST_CNT-1:0] MAX_CNT = W_BURST_CNT'(MAX_BURST);

  state_e                 state_q, state_d;
  logic [W_ID-1:0]        grant_id_q, grant_id_d;
  logic [W_ID-1:0]        last_grant_q, last_grant_d;
  logic [W_BURST_CNT-1:0] burst_cnt_q, burst_cnt_d;
  logic                   o_valid_q, o_valid_d;
  logic [W_DATA-1:0]      o_data_q, o_data_d;
  logic [W_ID-1:0]        o_id_q, o_id_d;

  logic [W_ID-1:0]        pick_id;
  logic                   pick_hit;
  logic                   up_ready;
  logic                   up_xfer;
  logic                   dn_xfer;

  pipe_pal_rr_pick #(
    .N_REQ (N_REQ),
    .W_ID  (W_ID)
  ) u_pick (
    .req        (i_req_valid),
    .last_grant (last_grant_q),
    .grant_id   (pick_id),
    .any_hit    (pick_hit)
  );

  // Arbitration FSM, upstream handshake and output register next-state.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    o_valid_d    = o_valid_q;
    o_data_d     = o_data_q;
    o_id_d       = o_id_q;
    o_req_ready  = '0;
    up_xfer      = 1'b0;
    up_ready     = !o_valid_q || i_ready;
    dn_xfer      = o_valid_q && i_ready;

    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d      = BURST;
          grant_id_d   = pick_id;
          last_grant_d = pick_id;
          burst_cnt_d  = '0;
        end
      end
      BURST: begin
        o_req_ready[grant_id_q] = up_ready;
        if (!i_req_valid[grant_id_q]) begin
          state_d = IDLE;
        end else if (up_ready) begin
          up_xfer     = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q + 1'b1 == MAX_CNT) begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // A load in the same cycle as a drain keeps o_valid high (1 beat/cycle).
    if (up_xfer) begin
      o_valid_d = 1'b1;
      o_data_d  = i_req_data[32'(grant_id_q)*W_DATA +: W_DATA];
      o_id_d    = grant_id_q;
    end else if (dn_xfer) begin
      o_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= W_ID'(N_REQ - 1);
      burst_cnt_q  <= '0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_id_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      o_id_q       <= o_id_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_id    = o_id_q;
  assign o_busy  = (state_q == BURST) || o_valid_q;

`ifdef PIPE_PAL_SCHED_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the datapath back-pressures a valid beat.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_valid_q && !i_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_pal_sched.sv
// tb_pipe_pal_sched: directed self-checking bench for pipe_pal_sched.
// Covers PIPE_PAL_SCHED_STATS_EN when the macro is defined.
module tb_pipe_pal_sched;

  logic         clk;
  logic         resetn;

  // Default instance: N_REQ=4, W_DATA=32, MAX_BURST=4
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         v;
  logic [31:0]  data;
  logic [1:0]   id;
  logic         ready;
  logic         busy;

  // Second instance: N_REQ=2, MAX_BURST=1
  logic [1:0]   req_valid2;
  logic [63:0]  req_data2;
  logic [1:0]   req_ready2;
  logic         v2;
  logic [31:0]  data2;
  logic [0:0]   id2;
  logic         ready2;
  logic         busy2;

`ifdef PIPE_PAL_SCHED_STATS_EN
  logic [15:0]  stall;
  logic [15:0]  stall2;
`endif

  int n_vec;
  int n_err;

  pipe_pal_sched #(
    .N_REQ     (4),
    .W_DATA    (32),
    .MAX_BURST (4)
  ) dut (
    .i_clk       (clk),
    .resetn      (resetn),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_valid     (v),
    .o_data      (data),
    .o_id        (id),
    .i_ready     (ready),
    .o_busy      (busy)
`ifdef PIPE_PAL_SCHED_STATS_EN
    ,
    .o_stall_cnt (stall)
`endif
  );

  pipe_pal_sched #(
    .N_REQ     (2),
    .W_DATA    (32),
    .MAX_BURST (1)
  ) dut2 (
    .i_clk       (clk),
    .resetn      (resetn),
    .i_req_valid (req_valid2),
    .i_req_data  (req_data2),
    .o_req_ready (req_ready2),
    .o_valid     (v2),
    .o_data      (data2),
    .o_id        (id2),
    .i_ready     (ready2),
    .o_busy      (busy2)
`ifdef PIPE_PAL_SCHED_STATS_EN
    ,
    .o_stall_cnt (stall2)
`endif
  );

  always #5 clk = ~clk;

  // Leaves the bench at a negedge with reset just released (IDLE cycle 0).
  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    ready     = 1'b1;
    resetn    = 1'b0;
    @(negedge clk);
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b exp %b", req_ready, 4'b0000); end
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", v); end
    n_vec++; if (data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", data); end
    n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d exp 0", id); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
`ifdef PIPE_PAL_SCHED_STATS_EN
    n_vec++; if (stall !== 16'h0) begin n_err++; $display("FAIL reset_stall got %h exp 0", stall); end
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [1:0]  exp_id;
    req_valid = 4'b1111;
    ready     = 1'b1;
    for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = 32'hCAFE_0000 + 32'(k);
    do_reset();
    for (int c = 0; c < 25; c++) begin
      exp_rdy = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
      exp_v   = (c > 0) && (c % 5 != 1);
      exp_id  = (c % 5 == 0) ? 2'(((c / 5) + 3) % 4) : 2'((c / 5) % 4);
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready c=%0d got %b exp %b", c, req_ready, exp_rdy); end
      n_vec++; if (v !== exp_v) begin n_err++; $display("FAIL rr_valid c=%0d got %b exp %b", c, v, exp_v); end
      n_vec++; if (busy !== (c != 0)) begin n_err++; $display("FAIL rr_busy c=%0d got %b exp %b", c, busy, (c != 0)); end
      if (exp_v) begin
        n_vec++; if (id !== exp_id) begin n_err++; $display("FAIL rr_id c=%0d got %0d exp %0d", c, id, exp_id); end
        n_vec++; if (data !== (32'hCAFE_0000 + 32'(exp_id))) begin n_err++; $display("FAIL rr_data c=%0d got %h exp %h", c, data, 32'hCAFE_0000 + 32'(exp_id)); end
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    req_valid = 4'b0100;
    ready     = 1'b0;
    req_data  = '0;
    req_data[64 +: 32] = 32'h2000_0000;
    do_reset();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_idle_ready got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_first_ready got %b exp 0100", req_ready); end
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL stall_first_valid got %b exp 0", v); end
    @(negedge clk); #1;
    req_data[64 +: 32] = 32'h2000_0001;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid c=%0d got %b exp 1", c, v); end
      n_vec++; if (id !== 2'd2) begin n_err++; $display("FAIL stall_hold_id c=%0d got %0d exp 2", c, id); end
      n_vec++; if (data !== 32'h2000_0000) begin n_err++; $display("FAIL stall_hold_data c=%0d got %h exp 20000000", c, data); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_hold_ready c=%0d got %b exp 0000", c, req_ready); end
      @(negedge clk); #1;
    end
    ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_resume_ready got %b exp 0100", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (data !== 32'h2000_0001) begin n_err++; $display("FAIL stall_beat1 got %h exp 20000001", data); end
    req_data[64 +: 32] = 32'h2000_0002;
    @(negedge clk); #1;
    n_vec++; if (data !== 32'h2000_0002) begin n_err++; $display("FAIL stall_beat2 got %h exp 20000002", data); end
    req_data[64 +: 32] = 32'h2000_0003;
    @(negedge clk); #1;
    n_vec++; if (data !== 32'h2000_0003 || v !== 1'b1) begin n_err++; $display("FAIL stall_beat3 got %h/%b exp 20000003/1", data, v); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_end_idle got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL stall_drained got %b exp 0", v); end
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_regrant got %b exp 0100", req_ready); end
  endtask

  task automatic test_drop();
    req_valid = 4'b0110;
    ready     = 1'b1;
    req_data  = '0;
    req_data[32 +: 32] = 32'h1111_0000;
    req_data[64 +: 32] = 32'h2222_0000;
    do_reset();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL drop_idle got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL drop_grant1 got %b exp 0010", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (v !== 1'b1 || id !== 2'd1) begin n_err++; $display("FAIL drop_beat1 got v=%b id=%0d exp v=1 id=1", v, id); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_vec++; if (v !== 1'b1 || id !== 2'd1) begin n_err++; $display("FAIL drop_beat2 got v=%b id=%0d exp v=1 id=1", v, id); end
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy got %b exp 0", busy); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL drop_idle_ready got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL drop_next_grant got %b exp 0100", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (v !== 1'b1 || id !== 2'd2 || data !== 32'h2222_0000) begin n_err++; $display("FAIL drop_next_beat got v=%b id=%0d d=%h exp 1/2/22220000", v, id, data); end
  endtask

  task automatic test_reset_midburst();
    req_valid = 4'b0010;
    ready     = 1'b0;
    req_data  = '0;
    req_data[32 +: 32] = 32'h1234_5678;
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (v !== 1'b1 || id !== 2'd1) begin n_err++; $display("FAIL mid_pre got v=%b id=%0d exp 1/1", v, id); end
    resetn = 1'b0;
    #1;
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b exp 0", v); end
    n_vec++; if (data !== 32'h0 || id !== 2'd0) begin n_err++; $display("FAIL mid_data got %h/%0d exp 0/0", data, id); end
    n_vec++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_busy got %b/%b exp 0/0000", busy, req_ready); end
    req_valid = 4'b1111;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_idle got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_regrant got %b exp 0001", req_ready); end
  endtask

  task automatic test_max_burst1();
    logic [1:0] exp_rdy;
    logic       exp_v;
    logic [0:0] exp_id;
    req_valid  = 4'b0000;
    req_valid2 = 2'b11;
    ready2     = 1'b1;
    req_data2  = {32'h0000_00B1, 32'h0000_00B0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      exp_rdy = (c % 2 == 0) ? 2'b00 : 2'(1 << ((c / 2) % 2));
      exp_v   = (c >= 2) && (c % 2 == 0);
      exp_id  = 1'(((c / 2) + 1) % 2);
      n_vec++; if (req_ready2 !== exp_rdy) begin n_err++; $display("FAIL mb1_ready c=%0d got %b exp %b", c, req_ready2, exp_rdy); end
      n_vec++; if (v2 !== exp_v) begin n_err++; $display("FAIL mb1_valid c=%0d got %b exp %b", c, v2, exp_v); end
      if (exp_v) begin
        n_vec++; if (id2 !== exp_id || data2 !== (32'h0000_00B0 + 32'(exp_id))) begin n_err++; $display("FAIL mb1_beat c=%0d got id=%0d d=%h exp id=%0d", c, id2, data2, exp_id); end
      end
      @(negedge clk);
      #1;
    end
    req_valid2 = 2'b00;
  endtask

`ifdef PIPE_PAL_SCHED_STATS_EN
  task automatic test_stats();
    req_valid = 4'b0001;
    ready     = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    #1;
    n_vec++; if (stall !== 16'd10) begin n_err++; $display("FAIL stats_early got %0d exp 10", stall); end
    repeat (70000) @(negedge clk);
    #1;
    n_vec++; if (stall !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat got %h exp FFFF", stall); end
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL stats_valid got %b exp 1", v); end
  endtask
`endif

  initial begin
    n_vec      = 0;
    n_err      = 0;
    clk        = 1'b0;
    resetn     = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    ready      = 1'b0;
    req_valid2 = '0;
    req_data2  = '0;
    ready2     = 1'b0;

    test_reset();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_midburst();
    test_max_burst1();
`ifdef PIPE_PAL_SCHED_STATS_EN
    test_stats();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_pal_sched.md
PIPE_PAL_SCHED -- requirements
Module: pipe_pal_sched

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (range 2..16).
REQ-002 Parameter W_DATA, default 32, SHALL set the payload width.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum beats per grant (range 1..255).
REQ-004 Localparam W_ID = clog2(N_REQ) SHALL set the requester-id width.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port i_clk: input, 1 bit, the single clock, rising edge.
REQ-007 Port resetn: input, 1 bit, asynchronous active-low reset.
REQ-008 Port i_req_valid: input, N_REQ bits, per-requester payload valid.
REQ-009 Port i_req_data: input, N_REQ*W_DATA bits, requester k's payload in slice [k*W_DATA +: W_DATA].
REQ-010 Port o_req_ready: output, N_REQ bits, per-requester accept; at most one bit high.
REQ-011 Port o_valid: output, 1 bit, payload valid toward the shared pipe_pal datapath.
REQ-012 Port o_data: output, W_DATA bits, forwarded payload.
REQ-013 Port o_id: output, W_ID bits, source requester of o_data.
REQ-014 Port i_ready: input, 1 bit, datapath accept.
REQ-015 Port o_busy: output, 1 bit, high while in BURST or while o_valid is high.

Function
REQ-016 A transfer on either side SHALL occur only when valid and ready are both high at a rising edge.
REQ-017 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-018 In IDLE with any i_req_valid bit high, the FSM SHALL grant round-robin starting at last_grant+1 modulo N_REQ, load grant_id, clear burst_cnt, and enter BURST next cycle; o_req_ready SHALL be all-zero in IDLE (one-cycle arbitration latency).
REQ-019 In BURST, o_req_ready[grant_id] SHALL equal (!o_valid || i_ready); all other bits SHALL be 0.
REQ-020 Each upstream transfer SHALL load o_data/o_id and set o_valid on the next edge (1-cycle latency); simultaneous drain and load SHALL sustain 1 beat/cycle.
REQ-021 o_valid SHALL drop after a drain only when no load occurs in the same cycle; o_data/o_id SHALL be stable while o_valid && !i_ready.
REQ-022 burst_cnt (8 bits) SHALL increment per upstream transfer; the transfer that makes burst_cnt reach MAX_BURST SHALL return the FSM to IDLE.
REQ-023 In BURST, a cycle with i_req_valid[grant_id] low SHALL return the FSM to IDLE without a transfer.
REQ-024 last_grant SHALL update to grant_id on each IDLE->BURST transition.
REQ-025 Requester validity dropping while o_req_ready is low SHALL be tolerated (no protocol error).
REQ-026 With only one requester active, it SHALL be re-granted after each IDLE cycle (MAX_BURST beats per MAX_BURST+1 cycles).

Reset
REQ-027 On resetn low, all state SHALL clear asynchronously: FSM=IDLE, o_valid=0, o_data=0, o_id=0, o_req_ready=0, o_busy=0, burst_cnt=0, last_grant=N_REQ-1, so requester 0 wins the first arbitration.
REQ-028 Reset mid-burst SHALL discard the registered beat; no recovery of the lost beat.

Configuration
REQ-029 When PIPE_PAL_SCHED_STATS_EN is defined, output o_stall_cnt (16 bits) SHALL count cycles with o_valid && !i_ready, saturate at 0xFFFF, and clear on reset.
REQ-030 When PIPE_PAL_SCHED_STATS_EN is undefined, o_stall_cnt and its logic SHALL be absent.

Structure
REQ-031 Package pipe_pal_pkg SHALL hold the state enum (IDLE, BURST) and the W_BURST_CNT=8 constant.
REQ-032 Sub-module pipe_pal_rr_pick SHALL implement the combinational round-robin picker (inputs: request vector and last_grant; outputs: grant id and any-hit flag).

Verification
REQ-033 Reset, then i_req_valid=4'b1111 with i_ready=1 held -> grants in order 0,1,2,3,0, each giving 4 beats and followed by one IDLE cycle.
REQ-034 Only requester 2 valid, i_ready=0 for 5 cycles after its first beat -> o_data/o_id=2 held stable for 5 cycles, o_req_ready=0, no beats lost.
REQ-035 Requester 1 deasserts valid after 2 beats -> FSM returns to IDLE; the next grant goes to the next active requester after 1.
REQ-036 resetn pulsed low during a BURST with o_valid=1 -> o_valid=0 immediately; the next grant goes to requester 0.
REQ-037 With PIPE_PAL_SCHED_STATS_EN defined, i_ready held 0 for 70000 cycles with o_valid=1 -> o_stall_cnt=0xFFFF.
REQ-038 MAX_BURST=1, two requesters active -> grants alternate every 2 cycles, 1 beat each.
